// File: rtl/seg7_serial_frame_decoder.sv
// Receives a serial 7-segment shift chain (active-low a..g,p per digit plus latch strobe),
// reassembles one frame of NUM_DIGITS bytes and decodes each byte to hex/point/blank/error.
module seg7_serial_frame_decoder #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ser_clk,
    input  logic                      ser_dat,
    input  logic                      ser_le,
    output logic [4*NUM_DIGITS-1:0]   hex_out,
    output logic [NUM_DIGITS-1:0]     point_out,
    output logic [NUM_DIGITS-1:0]     blank_out,
    output logic [NUM_DIGITS-1:0]     code_err,
    output logic                      frame_valid,
    output logic                      frame_err
);

    localparam int FRAME_BITS = 8 * NUM_DIGITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);

    // Returns {code_err, blank, hex[3:0]} for an active-low a..g pattern (bit6 = a).
    function automatic logic [5:0] decode_glyph(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            7'b0000001: res = 6'b00_0000;
            7'b1001111: res = 6'b00_0001;
            7'b0010010: res = 6'b00_0010;
            7'b0000110: res = 6'b00_0011;
            7'b1001100: res = 6'b00_0100;
            7'b0100100: res = 6'b00_0101;
            7'b0100000: res = 6'b00_0110;
            7'b0001111: res = 6'b00_0111;
            7'b0000000: res = 6'b00_1000;
            7'b0000100: res = 6'b00_1001;
            7'b0001000: res = 6'b00_1010;
            7'b1100000: res = 6'b00_1011;
            7'b0110001: res = 6'b00_1100;
            7'b1000010: res = 6'b00_1101;
            7'b0110000: res = 6'b00_1110;
            7'b0111000: res = 6'b00_1111;
            7'b1111111: res = 6'b01_0000;
            default:    res = 6'b10_0000;
        endcase
        return res;
    endfunction

    // Synchroniser stages packed as {le, dat, clk}
    logic [2:0]                meta_q, meta_d;
    logic [2:0]                sync_q, sync_d;
    logic [2:0]                prev_q, prev_d;
    logic [FRAME_BITS-1:0]     sreg_q, sreg_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0]   hex_q, hex_d;
    logic [NUM_DIGITS-1:0]     point_q, point_d;
    logic [NUM_DIGITS-1:0]     blank_q, blank_d;
    logic [NUM_DIGITS-1:0]     err_q, err_d;
    logic                      frame_valid_q, frame_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      clk_rise_s;
    logic                      le_rise_s;
    logic [5:0]                dec_s;

    assign clk_rise_s = sync_q[0] & ~prev_q[0];
    assign le_rise_s  = sync_q[2] & ~prev_q[2];

    // Next-state logic: synchronise, shift, count and commit or reject a frame at latch
    always_comb begin
        meta_d        = {ser_le, ser_dat, ser_clk};
        sync_d        = meta_q;
        prev_d        = sync_q;
        sreg_d        = sreg_q;
        cnt_d         = cnt_q;
        hex_d         = hex_q;
        point_d       = point_q;
        blank_d       = blank_q;
        err_d         = err_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        dec_s         = 6'b00_0000;

        if (clk_rise_s) begin
            sreg_d = {sreg_q[FRAME_BITS-2:0], sync_q[1]};
            if (cnt_q == CNT_OVF) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            sreg_d = sreg_q;
        end

        // A shift landing in the latch cycle is already folded into sreg_d/cnt_d
        if (le_rise_s) begin
            if (cnt_d == CNT_FULL) begin
                frame_valid_d = 1'b1;
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    dec_s            = decode_glyph(sreg_d[8*k+1 +: 7]);
                    hex_d[4*k +: 4]  = dec_s[3:0];
                    blank_d[k]       = dec_s[4];
                    err_d[k]         = dec_s[5];
                    point_d[k]       = ~sreg_d[8*k];
                end
            end else begin
                frame_err_d = 1'b1;
            end
            cnt_d = {CNT_W{1'b0}};
        end else begin
            frame_valid_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q        <= 3'b111;
            sync_q        <= 3'b111;
            prev_q        <= 3'b111;
            sreg_q        <= {FRAME_BITS{1'b1}};
            cnt_q         <= {CNT_W{1'b0}};
            hex_q         <= {(4*NUM_DIGITS){1'b0}};
            point_q       <= {NUM_DIGITS{1'b0}};
            blank_q       <= {NUM_DIGITS{1'b1}};
            err_q         <= {NUM_DIGITS{1'b0}};
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            sreg_q        <= sreg_d;
            cnt_q         <= cnt_d;
            hex_q         <= hex_d;
            point_q       <= point_d;
            blank_q       <= blank_d;
            err_q         <= err_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign hex_out     = hex_q;
    assign point_out   = point_q;
    assign blank_out   = blank_q;
    assign code_err    = err_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg7_serial_frame_decoder.sv
// Randomised and directed bench for seg7_serial_frame_decoder against a bit-queue reference model.
module tb_seg7_serial_frame_decoder;

    localparam int N  = 4;
    localparam int FB = 8 * N;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ser_clk = 1'b0;
    logic            ser_dat = 1'b0;
    logic            ser_le = 1'b0;
    logic [4*N-1:0]  hex_out;
    logic [N-1:0]    point_out;
    logic [N-1:0]    blank_out;
    logic [N-1:0]    code_err;
    logic            frame_valid;
    logic            frame_err;

    seg7_serial_frame_decoder #(.NUM_DIGITS(N)) dut (
        .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_dat(ser_dat), .ser_le(ser_le),
        .hex_out(hex_out), .point_out(point_out), .blank_out(blank_out), .code_err(code_err),
        .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bits received (last FB kept), saturating count, expected outputs
    bit             mq[$];
    int             mcnt = 0;
    logic [4*N-1:0] e_hex = '0;
    logic [N-1:0]   e_pt = '0;
    logic [N-1:0]   e_bl = '1;
    logic [N-1:0]   e_er = '0;

    logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    function automatic logic [7:0] enc(input int v, input bit p);
        return {glyph[v], p};
    endfunction

    function automatic logic [27:0] exp_vec();
        return {e_hex, e_pt, e_bl, e_er};
    endfunction

    function automatic logic [27:0] out_vec();
        return {hex_out, point_out, blank_out, code_err};
    endfunction

    task automatic model_push(input bit b);
        mq.push_back(b);
        if (mq.size() > FB) void'(mq.pop_front());
        if (mcnt < FB + 1) mcnt++;
    endtask

    task automatic model_latch();
        logic [7:0] by;
        bit found;
        if (mcnt == FB) begin
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < 8; j++) by[7-j] = mq[(N-1-k)*8 + j];
                found = 0;
                e_hex[4*k +: 4] = 4'h0;
                e_bl[k] = 1'b0;
                e_er[k] = 1'b0;
                for (int v = 0; v < 16; v++) begin
                    if (!found && glyph[v] == by[7:1]) begin
                        found = 1;
                        e_hex[4*k +: 4] = v[3:0];
                    end
                end
                if (!found) begin
                    if (by[7:1] == 7'h7F) e_bl[k] = 1'b1;
                    else e_er[k] = 1'b1;
                end
                e_pt[k] = ~by[0];
            end
        end
        mcnt = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        mcnt  = 0;
        e_hex = '0;
        e_pt  = '0;
        e_bl  = '1;
        e_er  = '0;
    endtask

    task automatic send_bit(input bit b);
        @(posedge clk); #2 ser_dat = b;
        repeat (2) @(posedge clk);
        #2 ser_clk = 1'b1;
        repeat (3) @(posedge clk);
        #2 ser_clk = 1'b0;
        model_push(b);
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic [7:0] t;
        t = v;
        for (int i = 7; i >= 0; i--) send_bit(t[i]);
    endtask

    task automatic send_frame(input logic [31:0] f);
        logic [31:0] t;
        t = f;
        for (int d = 3; d >= 0; d--) send_byte(t[8*d +: 8]);
    endtask

    // Watch a latch window, counting pulses and snapshotting outputs when frame_valid is high
    task automatic watch(output int nfv, output int nfe, output logic [27:0] snap);
        nfv = 0; nfe = 0; snap = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin nfv++; snap = out_vec(); end
            if (frame_err === 1'b1) nfe++;
        end
    endtask

    task automatic do_latch(output int nfv, output int nfe, output logic [27:0] snap);
        @(posedge clk); #2 ser_le = 1'b1;
        model_latch();
        watch(nfv, nfe, snap);
        @(posedge clk); #2 ser_le = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        n_tests++;
        if (out_vec() !== {16'h0000, 4'h0, 4'hF, 4'h0} || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got %h fv=%b fe=%b, expected %h fv=0 fe=0",
                     out_vec(), frame_valid, frame_err, {16'h0000, 4'h0, 4'hF, 4'h0});
        end
    endtask

    task automatic test_basic();
        int nfv, nfe; logic [27:0] snap;
        send_frame({8'h02, 8'h9F, 8'h25, 8'h0D});
        do_latch(nfv, nfe, snap);
        n_tests++;
        if (nfv != 1 || nfe != 0) begin
            n_fail++; $display("FAIL basic_pulses: got fv=%0d fe=%0d, expected 1 0", nfv, nfe);
        end
        n_tests++;
        if (snap !== {16'h0123, 4'b1000, 4'h0, 4'h0} || out_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL basic_outputs: got snap=%h out=%h, expected %h", snap, out_vec(), exp_vec());
        end
    endtask

    task automatic test_sweep();
        int nfv, nfe; logic [27:0] snap;
        for (int f = 0; f < 4; f++) begin
            for (int d = 0; d < 4; d++) send_byte(enc(4*f + d, 1'b1));
            do_latch(nfv, nfe, snap);
            n_tests++;
            if (nfv != 1 || nfe != 0 || snap !== exp_vec() || e_er !== 4'h0 || e_pt !== 4'h0) begin
                n_fail++;
                $display("FAIL sweep%0d: got fv=%0d fe=%0d snap=%h, expected fv=1 fe=0 %h", f, nfv, nfe, snap, exp_vec());
            end
        end
        n_tests++;
        if (hex_out !== 16'hCDEF) begin
            n_fail++; $display("FAIL sweep_last: got %h expected cdef", hex_out);
        end
    endtask

    task automatic test_special();
        int nfv, nfe; logic [27:0] snap;
        send_frame({8'hFF, 8'hFE, 8'h03, 8'h55});
        do_latch(nfv, nfe, snap);
        n_tests++;
        if (nfv != 1 || snap !== {16'h0000, 4'b0100, 4'b1100, 4'b0001} || snap !== exp_vec()) begin
            n_fail++; $display("FAIL special: got fv=%0d snap=%h, expected fv=1 %h", nfv, snap, exp_vec());
        end
    endtask

    task automatic test_bad_count();
        int nfv, nfe; logic [27:0] snap, held;
        held = out_vec();
        for (int i = 0; i < 31; i++) send_bit(1'($urandom_range(0, 1)));
        do_latch(nfv, nfe, snap);
        n_tests++;
        if (nfv != 0 || nfe != 1 || out_vec() !== held) begin
            n_fail++; $display("FAIL short_frame: got fv=%0d fe=%0d out=%h, expected 0 1 %h", nfv, nfe, out_vec(), held);
        end
        for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
        do_latch(nfv, nfe, snap);
        n_tests++;
        if (nfv != 0 || nfe != 1 || out_vec() !== held) begin
            n_fail++; $display("FAIL long_frame: got fv=%0d fe=%0d out=%h, expected 0 1 %h", nfv, nfe, out_vec(), held);
        end
        send_frame({enc(7, 1'b0), enc(10, 1'b1), enc(2, 1'b1), enc(15, 1'b0)});
        do_latch(nfv, nfe, snap);
        n_tests++;
        if (nfv != 1 || nfe != 0 || snap !== exp_vec() || hex_out !== 16'h7A2F) begin
            n_fail++; $display("FAIL recover: got fv=%0d fe=%0d snap=%h, expected 1 0 %h", nfv, nfe, snap, exp_vec());
        end
    endtask

    task automatic test_random();
        int nfv, nfe; logic [27:0] snap; logic [7:0] b;
        for (int f = 0; f < 6; f++) begin
            for (int d = 0; d < 4; d++) begin
                case ($urandom_range(0, 3))
                    0, 1:    b = enc(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                    2:       b = {7'h7F, 1'($urandom_range(0, 1))};
                    default: b = 8'($urandom);
                endcase
                send_byte(b);
            end
            do_latch(nfv, nfe, snap);
            n_tests++;
            if (nfv != 1 || nfe != 0 || snap !== exp_vec()) begin
                n_fail++; $display("FAIL random%0d: got fv=%0d fe=%0d snap=%h, expected 1 0 %h", f, nfv, nfe, snap, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int nfv, nfe; logic [27:0] snap;
        for (int i = 0; i < 31; i++) send_bit(1'($urandom_range(0, 1)));
        // 32nd bit's clock rise and the latch rise happen together
        @(posedge clk); #2 ser_dat = 1'b1;
        repeat (2) @(posedge clk);
        #2 ser_clk = 1'b1; ser_le = 1'b1;
        model_push(1'b1);
        model_latch();
        watch(nfv, nfe, snap);
        @(posedge clk); #2 ser_clk = 1'b0; ser_le = 1'b0;
        repeat (3) @(posedge clk);
        n_tests++;
        if (nfv != 1 || nfe != 0 || snap !== exp_vec()) begin
            n_fail++; $display("FAIL same_cycle: got fv=%0d fe=%0d snap=%h, expected 1 0 %h", nfv, nfe, snap, exp_vec());
        end
    endtask

    task automatic test_reset_midframe();
        int nfv, nfe; logic [27:0] snap;
        for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
        @(posedge clk); #2 ser_clk = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        watch(nfv, nfe, snap);
        n_tests++;
        if (nfv != 0 || nfe != 0 || out_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_release: got fv=%0d fe=%0d out=%h, expected 0 0 %h", nfv, nfe, out_vec(), exp_vec());
        end
        #2 ser_clk = 1'b0;
        for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
        do_latch(nfv, nfe, snap);
        n_tests++;
        if (nfv != 0 || nfe != 1 || out_vec() !== {16'h0000, 4'h0, 4'hF, 4'h0}) begin
            n_fail++; $display("FAIL reset_partial: got fv=%0d fe=%0d out=%h, expected 0 1 %h",
                               nfv, nfe, out_vec(), {16'h0000, 4'h0, 4'hF, 4'h0});
        end
        // A second reset with ser_clk high, then an exact frame: a spurious shift would spoil the count
        @(posedge clk); #2 ser_clk = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2 ser_clk = 1'b0;
        send_frame({enc(4, 1'b0), enc(11, 1'b1), enc(12, 1'b0), enc(9, 1'b1)});
        do_latch(nfv, nfe, snap);
        n_tests++;
        if (nfv != 1 || nfe != 0 || snap !== exp_vec()) begin
            n_fail++; $display("FAIL reset_exact: got fv=%0d fe=%0d snap=%h, expected 1 0 %h", nfv, nfe, snap, exp_vec());
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_basic();
        test_sweep();
        test_special();
        test_bad_count();
        test_random();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
